// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: key-length encodings, per-length
// geometry lookups, GF(2^8) doubling for Rcon, the S-box table and FSM states.
package aes_pkg;

  localparam logic [1:0] KEY_LEN_128  = 2'b00;
  localparam logic [1:0] KEY_LEN_192  = 2'b01;
  localparam logic [1:0] KEY_LEN_256  = 2'b10;
  localparam logic [1:0] KEY_LEN_RSVD = 2'b11;

  localparam logic [7:0] RCON_RST = 8'h01;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Key length in 32-bit words; 0 marks the reserved encoding.
  function automatic logic [3:0] nk_of(input logic [1:0] len);
    case (len)
      KEY_LEN_128: return 4'd4;
      KEY_LEN_192: return 4'd6;
      KEY_LEN_256: return 4'd8;
      default:     return 4'd0;
    endcase
  endfunction

  // Number of rounds, i.e. highest readable round-key index.
  function automatic logic [3:0] nr_of(input logic [1:0] len);
    case (len)
      KEY_LEN_128: return 4'd10;
      KEY_LEN_192: return 4'd12;
      KEY_LEN_256: return 4'd14;
      default:     return 4'd0;
    endcase
  endfunction

  // Total schedule length in words, 4*(Nr+1).
  function automatic logic [5:0] nwords_of(input logic [1:0] len);
    case (len)
      KEY_LEN_128: return 6'd44;
      KEY_LEN_192: return 6'd52;
      KEY_LEN_256: return 6'd60;
      default:     return 6'd0;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TABLE[8 * (255 - int'(x)) +: 8];
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Single-byte AES forward S-box lookup (combinational).
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] byte_i,
  output logic [7:0] byte_o
);

  assign byte_o = sbox(byte_i);

endmodule

// File: rtl/aes_sub_word.sv
// 32-bit SubWord: four parallel S-boxes, one per byte lane. Purely combinational.
module aes_sub_word (
  input  logic [31:0] word_i,
  output logic [31:0] word_o
);

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    aes_sbox u_sbox (
      .byte_i (word_i[8*gi +: 8]),
      .byte_o (word_o[8*gi +: 8])
    );
  end

endmodule

// File: rtl/key_expansion_iter.sv
// Iterative AES-128/192/256 key schedule: one word per cycle through a single
// shared SubWord unit, with every word kept in an array readable by round index.
module key_expansion_iter
  import aes_pkg::*;
#(
  parameter int MAX_NK = 8,
  parameter int RD_REG = 1
) (
  input  logic         clk,
  input  logic         i_Rst_n,
  input  logic         i_Start,
  input  logic [1:0]   i_Key_Len,
  input  logic [255:0] i_Key,
  input  logic [3:0]   i_Rd_Round,
  output logic [127:0] o_Round_Key,
  output logic         o_Busy,
  output logic         o_Done,
  output logic         o_Key_Valid,
  output logic         o_Err
);

  localparam int NW = 4 * (MAX_NK + 7);
  localparam int IW = $clog2(NW);

  state_e          state_q, state_d;
  logic [1:0]      len_q, len_d;
  logic [IW-1:0]   i_q, i_d;
  logic [2:0]      j_q, j_d;
  logic [7:0]      rcon_q, rcon_d;
  logic            busy_q, busy_d, done_q, done_d, valid_q, valid_d, err_q, err_d;
  logic            load_en, wr_en;
  logic [31:0]     w_q [NW];

  logic [3:0]      nk_cur, nr_cur, load_nk;
  logic [IW-1:0]   prev_idx, back_idx, rd_base;
  logic [31:0]     w_prev, w_back, sub_in, sub_out, t_word, w_new;
  logic [7:0][31:0] key_words;
  logic [127:0]    rd_data;

  assign nk_cur    = nk_of(len_q);
  assign nr_cur    = nr_of(len_q);
  assign load_nk   = nk_of(i_Key_Len);
  assign key_words = i_Key;

  // Datapath for w[i]: RotWord is muxed ahead of the shared SubWord only on j==0.
  assign prev_idx = i_q - IW'(1);
  assign back_idx = i_q - IW'(nk_cur);
  assign w_prev   = w_q[prev_idx];
  assign w_back   = w_q[back_idx];
  assign sub_in   = (j_q == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

  aes_sub_word u_sub_word (
    .word_i (sub_in),
    .word_o (sub_out)
  );

  // Select the transformed temp word for this position within the Nk-word group.
  always_comb begin
    t_word = w_prev;
    if (j_q == 3'd0) begin
      t_word = sub_out ^ {rcon_q, 24'h0};
    end else if (nk_cur == 4'd8 && j_q == 3'd4) begin
      t_word = sub_out;
    end
  end

  assign w_new = w_back ^ t_word;

  // Next-state and control: accept/reject start, step counters, frame completion.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    i_d     = i_q;
    j_d     = j_q;
    rcon_d  = rcon_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    valid_d = valid_q;
    err_d   = 1'b0;
    load_en = 1'b0;
    wr_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_Start) begin
          if (i_Key_Len != KEY_LEN_RSVD && int'(load_nk) <= MAX_NK) begin
            load_en = 1'b1;
            len_d   = i_Key_Len;
            i_d     = IW'(load_nk);
            j_d     = 3'd0;
            rcon_d  = RCON_RST;
            valid_d = 1'b0;
            busy_d  = 1'b1;
            state_d = ST_EXPAND;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_EXPAND: begin
        wr_en = 1'b1;
        i_d   = i_q + IW'(1);
        j_d   = ({1'b0, j_q} == nk_cur - 4'd1) ? 3'd0 : j_q + 3'd1;
        if (j_q == 3'd0) begin
          rcon_d = xtime(rcon_q);
        end
        if (i_q == IW'(nwords_of(len_q) - 6'd1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control registers and registered status outputs.
  always_ff @(posedge clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q <= ST_IDLE;
      len_q   <= KEY_LEN_128;
      i_q     <= '0;
      j_q     <= '0;
      rcon_q  <= RCON_RST;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      i_q     <= i_d;
      j_q     <= j_d;
      rcon_q  <= rcon_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // Word array: key words load on accept, then one expanded word per cycle.
  always_ff @(posedge clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      for (int k = 0; k < NW; k++) w_q[k] <= '0;
    end else if (load_en) begin
      for (int k = 0; k < MAX_NK; k++) begin
        if (k < int'(load_nk)) w_q[k] <= key_words[7-k];
      end
    end else if (wr_en) begin
      w_q[i_q] <= w_new;
    end
  end

  // Read mux: rounds beyond Nr of the stored length read as zero.
  assign rd_base = IW'({i_Rd_Round, 2'b00});
  always_comb begin
    rd_data = '0;
    if (i_Rd_Round <= nr_cur && int'(i_Rd_Round) * 4 + 3 < NW) begin
      rd_data = {w_q[rd_base], w_q[rd_base + IW'(1)],
                 w_q[rd_base + IW'(2)], w_q[rd_base + IW'(3)]};
    end
  end

  if (RD_REG != 0) begin : g_rd_reg
    // Registered read port, one cycle of latency.
    always_ff @(posedge clk or negedge i_Rst_n) begin
      if (!i_Rst_n) o_Round_Key <= '0;
      else          o_Round_Key <= rd_data;
    end
  end else begin : g_rd_comb
    assign o_Round_Key = rd_data;
  end

  assign o_Busy      = busy_q;
  assign o_Done      = done_q;
  assign o_Key_Valid = valid_q;
  assign o_Err       = err_q;

endmodule

// File: tb/tb_key_expansion_iter.sv
// Directed bench for key_expansion_iter using FIPS-197 Appendix A key vectors.
module tb_key_expansion_iter;

  logic         clk = 1'b0;
  logic         i_Rst_n = 1'b0;
  logic         i_Start = 1'b0;
  logic [1:0]   i_Key_Len = 2'b00;
  logic [255:0] i_Key = '0;
  logic [3:0]   i_Rd_Round = 4'd0;
  logic [127:0] o_Round_Key;
  logic         o_Busy, o_Done, o_Key_Valid, o_Err;

  int errors = 0;
  int checks = 0;

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  localparam logic [127:0] R128_0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] R128_1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] R128_2  = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] R128_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] R192_1  = 128'h62f8ead2522c6b7bfe0c91f72402f5a5;
  localparam logic [127:0] R192_12 = 128'he98ba06f448c773c8ecc720401002202;
  localparam logic [127:0] R256_1  = 128'h1f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] R256_2  = 128'h9ba354118e6925afa51a8b5f2067fcde;
  localparam logic [127:0] R256_14 = 128'hfe4890d1e6188d0b046df344706c631e;

  key_expansion_iter #(.MAX_NK(8), .RD_REG(1)) dut (
    .clk         (clk),
    .i_Rst_n     (i_Rst_n),
    .i_Start     (i_Start),
    .i_Key_Len   (i_Key_Len),
    .i_Key       (i_Key),
    .i_Rd_Round  (i_Rd_Round),
    .o_Round_Key (o_Round_Key),
    .o_Busy      (o_Busy),
    .o_Done      (o_Done),
    .o_Key_Valid (o_Key_Valid),
    .o_Err       (o_Err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_exp(input logic [1:0] len, input logic [255:0] key);
    i_Key_Len = len;
    i_Key     = key;
    i_Start   = 1'b1;
    step();
    i_Start   = 1'b0;
  endtask

  // Cycles after the accepting edge until o_Done is seen; -1 on timeout.
  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int n = 1; n <= 200; n++) begin
      step();
      if (o_Done) begin
        cyc = n;
        break;
      end
    end
  endtask

  task automatic read_round(input logic [3:0] r, output logic [127:0] k);
    i_Rd_Round = r;
    step();
    k = o_Round_Key;
  endtask

  task automatic test_reset();
    step();
    step();
    checks++;
    if ({o_Busy, o_Done, o_Key_Valid, o_Err} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 0000", {o_Busy, o_Done, o_Key_Valid, o_Err});
    end
    checks++;
    if (o_Round_Key !== 128'h0) begin
      errors++;
      $display("FAIL reset_key: got %h expected 0", o_Round_Key);
    end
    i_Rst_n = 1'b1;
    step();
    checks++;
    if ({o_Busy, o_Done, o_Key_Valid, o_Err} !== 4'b0000) begin
      errors++;
      $display("FAIL post_reset_flags: got %b expected 0000", {o_Busy, o_Done, o_Key_Valid, o_Err});
    end
    $display("reset: released");
  endtask

  task automatic test_aes128();
    int cyc;
    logic [127:0] k;
    start_exp(2'b00, K128);
    checks++;
    if ({o_Busy, o_Key_Valid} !== 2'b10) begin
      errors++;
      $display("FAIL aes128_busy: got busy/valid %b expected 10", {o_Busy, o_Key_Valid});
    end
    wait_done(cyc);
    checks++;
    if (cyc !== 41) begin
      errors++;
      $display("FAIL aes128_latency: got %0d expected 41", cyc);
    end
    checks++;
    if ({o_Busy, o_Key_Valid} !== 2'b01) begin
      errors++;
      $display("FAIL aes128_done_flags: got busy/valid %b expected 01", {o_Busy, o_Key_Valid});
    end
    read_round(4'd0, k);
    checks++;
    if (k !== R128_0) begin errors++; $display("FAIL aes128_r0: got %h expected %h", k, R128_0); end
    read_round(4'd1, k);
    checks++;
    if (k !== R128_1) begin errors++; $display("FAIL aes128_r1: got %h expected %h", k, R128_1); end
    read_round(4'd2, k);
    checks++;
    if (k !== R128_2) begin errors++; $display("FAIL aes128_r2: got %h expected %h", k, R128_2); end
    read_round(4'd10, k);
    checks++;
    if (k !== R128_10) begin errors++; $display("FAIL aes128_r10: got %h expected %h", k, R128_10); end
    $display("aes128: done after %0d cycles, round10 %h", cyc, k);
  endtask

  task automatic test_illegal_len();
    logic [127:0] k;
    start_exp(2'b11, K256);
    checks++;
    if ({o_Err, o_Busy, o_Key_Valid} !== 3'b101) begin
      errors++;
      $display("FAIL err_pulse: got err/busy/valid %b expected 101", {o_Err, o_Busy, o_Key_Valid});
    end
    step();
    checks++;
    if ({o_Err, o_Busy, o_Key_Valid} !== 3'b001) begin
      errors++;
      $display("FAIL err_after: got err/busy/valid %b expected 001", {o_Err, o_Busy, o_Key_Valid});
    end
    read_round(4'd10, k);
    checks++;
    if (k !== R128_10) begin errors++; $display("FAIL err_keep_r10: got %h expected %h", k, R128_10); end
    $display("illegal_len: err pulse seen, schedule kept");
  endtask

  task automatic test_rd_range();
    logic [127:0] k;
    read_round(4'd11, k);
    checks++;
    if (k !== 128'h0) begin errors++; $display("FAIL rd_r11: got %h expected 0", k); end
    read_round(4'd15, k);
    checks++;
    if (k !== 128'h0) begin errors++; $display("FAIL rd_r15: got %h expected 0", k); end
    $display("rd_range: rounds 11 and 15 read zero");
  endtask

  task automatic test_ignore_start();
    int cyc;
    logic [127:0] k;
    start_exp(2'b00, K128);
    for (int n = 0; n < 10; n++) step();
    i_Key_Len = 2'b10;
    i_Key     = K256;
    i_Start   = 1'b1;
    step();
    i_Start   = 1'b0;
    checks++;
    if ({o_Busy, o_Err} !== 2'b10) begin
      errors++;
      $display("FAIL ignore_busy: got busy/err %b expected 10", {o_Busy, o_Err});
    end
    wait_done(cyc);
    if (cyc >= 0) cyc = cyc + 11;
    checks++;
    if (cyc !== 41) begin errors++; $display("FAIL ignore_latency: got %0d expected 41", cyc); end
    read_round(4'd10, k);
    checks++;
    if (k !== R128_10) begin errors++; $display("FAIL ignore_r10: got %h expected %h", k, R128_10); end
    $display("ignore_start: done after %0d cycles, round10 %h", cyc, k);
  endtask

  task automatic test_reset_mid();
    int cyc;
    logic [127:0] k;
    start_exp(2'b10, K256);
    for (int n = 0; n < 20; n++) step();
    i_Rst_n = 1'b0;
    #1;
    checks++;
    if ({o_Busy, o_Done, o_Key_Valid, o_Err} !== 4'b0000 || o_Round_Key !== 128'h0) begin
      errors++;
      $display("FAIL midreset_outputs: got flags %b key %h expected 0000 and 0",
               {o_Busy, o_Done, o_Key_Valid, o_Err}, o_Round_Key);
    end
    step();
    step();
    i_Rst_n = 1'b1;
    step();
    start_exp(2'b10, K256);
    wait_done(cyc);
    checks++;
    if (cyc !== 53) begin errors++; $display("FAIL aes256_latency: got %0d expected 53", cyc); end
    checks++;
    if (o_Key_Valid !== 1'b1) begin errors++; $display("FAIL aes256_valid: got %b expected 1", o_Key_Valid); end
    read_round(4'd1, k);
    checks++;
    if (k !== R256_1) begin errors++; $display("FAIL aes256_r1: got %h expected %h", k, R256_1); end
    read_round(4'd2, k);
    checks++;
    if (k !== R256_2) begin errors++; $display("FAIL aes256_r2: got %h expected %h", k, R256_2); end
    read_round(4'd14, k);
    checks++;
    if (k !== R256_14) begin errors++; $display("FAIL aes256_r14: got %h expected %h", k, R256_14); end
    $display("reset_mid: restart aes256 done after %0d cycles, round14 %h", cyc, k);
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [127:0] k;
    i_Rd_Round = 4'd10;
    start_exp(2'b00, K128);
    wait_done(cyc);
    checks++;
    if (cyc !== 41) begin errors++; $display("FAIL b2b_128_latency: got %0d expected 41", cyc); end
    checks++;
    if (o_Round_Key !== R128_10 || o_Key_Valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_128_r10: got %h valid %b expected %h valid 1", o_Round_Key, o_Key_Valid, R128_10);
    end
    start_exp(2'b01, K192);
    checks++;
    if ({o_Busy, o_Key_Valid} !== 2'b10) begin
      errors++;
      $display("FAIL b2b_between: got busy/valid %b expected 10", {o_Busy, o_Key_Valid});
    end
    wait_done(cyc);
    checks++;
    if (cyc !== 47) begin errors++; $display("FAIL b2b_192_latency: got %0d expected 47", cyc); end
    read_round(4'd1, k);
    checks++;
    if (k !== R192_1) begin errors++; $display("FAIL b2b_192_r1: got %h expected %h", k, R192_1); end
    read_round(4'd12, k);
    checks++;
    if (k !== R192_12) begin errors++; $display("FAIL b2b_192_r12: got %h expected %h", k, R192_12); end
    read_round(4'd13, k);
    checks++;
    if (k !== 128'h0) begin errors++; $display("FAIL b2b_192_r13: got %h expected 0", k); end
    $display("back_to_back: aes192 done after %0d cycles, round12 %h", cyc, R192_12);
  endtask

  initial begin
    test_reset();
    test_aes128();
    test_illegal_len();
    test_rd_range();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
